// File: rtl/sram_burst_initiator.sv
// Burst initiator for a single-port SRAM macro (1-cycle read latency).
// Sequences write/read bursts and buffers read beats in a 2-entry FIFO.
module sram_burst_initiator #(
    parameter int AW   = 9,
    parameter int DW   = 16,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [LENW-1:0] req_len,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    input  logic [DW-1:0]   wdata,
    output logic            rdata_valid,
    input  logic            rdata_ready,
    output logic [DW-1:0]   rdata,
    output logic            rdata_last,
    output logic            busy,
    output logic [AW-1:0]   sram_adr,
    output logic [DW-1:0]   sram_d,
    output logic            sram_we,
    output logic            sram_me,
    input  logic [DW-1:0]   sram_q,
    output logic [1:0]      state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and ready may depend on state only.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cur_addr;
    logic [LENW:0]   beats_left;
    logic            inflight;
    logic            inflight_last;
    logic [DW-1:0]   buf_data [2];
    logic [1:0]      buf_last;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ;

    logic            accept;
    logic            wr_beat;
    logic            issue;
    logic            pop;
    logic            push;
    logic [2:0]      pending;

    assign state_dbg = state;

    // occ + inflight - pop < 2, rearranged so it never goes negative
    assign pending = {1'b0, occ} + {2'b00, inflight};

    always_comb begin
        accept      = 1'b0;
        wr_beat     = 1'b0;
        issue       = 1'b0;
        pop         = 1'b0;
        push        = inflight;
        state_nxt   = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        if (!rst) begin
            req_ready   = (state == IDLE);
            wdata_ready = (state == WRITE);
            accept      = (state == IDLE) && req_valid;
            wr_beat     = (state == WRITE) && wdata_valid;
            pop         = (state == READ) && (occ != 2'd0) && rdata_ready;
            issue       = (state == READ) && (beats_left != '0) &&
                          (pending < (3'd2 + {2'b00, pop}));
        end
        case (state)
            IDLE:  if (accept) state_nxt = req_write ? WRITE : READ;
            WRITE: if (wr_beat && beats_left == {{LENW{1'b0}}, 1'b1}) state_nxt = IDLE;
            READ:  if (pop && buf_last[rd_ptr]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rdata_valid = !rst && (occ != 2'd0);
    assign rdata       = buf_data[rd_ptr];
    assign rdata_last  = rdata_valid && buf_last[rd_ptr];
    assign busy        = !rst && (state != IDLE);
    assign sram_adr    = cur_addr;
    assign sram_d      = wdata;
    assign sram_me     = wr_beat || issue;
    assign sram_we     = wr_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur_addr   <= req_addr;
                beats_left <= {1'b0, req_len} + {{LENW{1'b0}}, 1'b1};
            end else if (wr_beat || issue) begin
                // wraps naturally modulo 2**AW
                cur_addr   <= cur_addr + {{(AW-1){1'b0}}, 1'b1};
                beats_left <= beats_left - {{LENW{1'b0}}, 1'b1};
            end
            inflight      <= issue;
            inflight_last <= issue && (beats_left == {{LENW{1'b0}}, 1'b1});
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Buffer storage needs no reset; occ alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_data[wr_ptr] <= sram_q;
            buf_last[wr_ptr] <= inflight_last;
        end
    end

endmodule

// File: tb/tb_sram_burst_initiator.sv
// Directed bench for sram_burst_initiator with a behavioural SRAM macro,
// write/read logging and hand-computed expected queues.
module tb_sram_burst_initiator;
    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int LENW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [LENW-1:0] req_len;
    logic            wdata_valid;
    logic            wdata_ready;
    logic [DW-1:0]   wdata;
    logic            rdata_valid;
    logic            rdata_ready;
    logic [DW-1:0]   rdata;
    logic            rdata_last;
    logic            busy;
    logic [AW-1:0]   sram_adr;
    logic [DW-1:0]   sram_d;
    logic            sram_we;
    logic            sram_me;
    logic [DW-1:0]   sram_q;
    logic [1:0]      state_dbg;

    sram_burst_initiator #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy),
        .sram_adr(sram_adr), .sram_d(sram_d), .sram_we(sram_we), .sram_me(sram_me),
        .sram_q(sram_q), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM macro model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_me) begin
            if (sram_we) mem[sram_adr] <= sram_d;
            else         sram_q        <= mem[sram_adr];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [AW+DW-1:0] wr_log[$];
    logic [AW+DW-1:0] exp_wq[$];
    logic [DW:0]      rd_log[$];
    logic [DW:0]      exp_q[$];
    int               rd_cyc[$];
    int               iss_cyc[$];
    int               out_cnt = 0;
    int               max_out = 0;
    int               bad_me  = 0;

    always @(negedge clk) begin
        #2;
        if (sram_me && sram_we) wr_log.push_back({sram_adr, sram_d});
        if (sram_me && sram_we && !wdata_valid) bad_me++;
        if (sram_we && !sram_me) bad_me++;
        if (sram_me && !sram_we) begin
            iss_cyc.push_back(cyc);
            out_cnt++;
        end
        if (rdata_valid && rdata_ready) begin
            rd_log.push_back({rdata_last, rdata});
            rd_cyc.push_back(cyc);
            out_cnt--;
        end
        if (out_cnt > max_out) max_out = out_cnt;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_log.delete(); exp_wq.delete(); rd_log.delete(); exp_q.delete();
        rd_cyc.delete(); iss_cyc.delete();
        out_cnt = 0; max_out = 0; bad_me = 0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wr_log.size(), exp_wq.size());
        while (wr_log.size() > 0 && exp_wq.size() > 0)
            chk(tag, wr_log.pop_front(), exp_wq.pop_front());
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_count"}, rd_log.size(), exp_q.size());
        while (rd_log.size() > 0 && exp_q.size() > 0)
            chk(tag, rd_log.pop_front(), exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic wr, input logic [AW-1:0] addr, input logic [LENW-1:0] len);
        int waited = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        #1;
        while (!req_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("req_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [LENW-1:0] len,
                               input logic [DW-1:0] base);
        send_req(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            wdata_valid = 1'b1;
            wdata = base + DW'(i);
            @(negedge clk);
        end
        wdata_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;

        // 1: reset behaviour
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_me", sram_me, 0);
            chk("rst_rvalid", rdata_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_state", state_dbg, 0);
        chk("post_rst_adr", sram_adr, 0);

        // 2: write burst wrapping the top of memory
        @(negedge clk);
        clear_logs();
        write_burst(9'h1FE, 4'd3, 16'hA000);
        #1;
        chk("wr_busy_after_last", busy, 0);
        exp_wq.push_back({9'h1FE, 16'hA000});
        exp_wq.push_back({9'h1FF, 16'hA001});
        exp_wq.push_back({9'h000, 16'hA002});
        exp_wq.push_back({9'h001, 16'hA003});
        check_writes("wr_wrap");

        // 3: read it back at full rate
        @(negedge clk);
        clear_logs();
        rdata_ready = 1'b1;
        send_req(1'b0, 9'h1FE, 4'd3);
        wait_idle(20);
        exp_q.push_back({1'b0, 16'hA000});
        exp_q.push_back({1'b0, 16'hA001});
        exp_q.push_back({1'b0, 16'hA002});
        exp_q.push_back({1'b1, 16'hA003});
        chk("rd_issue_count", iss_cyc.size(), 4);
        if (rd_cyc.size() == 4 && iss_cyc.size() > 0) begin
            chk("rd_first_latency", rd_cyc[0] - iss_cyc[0], 2);
            for (int i = 1; i < 4; i++) chk("rd_back_to_back", rd_cyc[i] - rd_cyc[0], i);
        end
        check_reads("rd_wrap");

        // 4: long read with a 5-cycle downstream stall
        @(negedge clk);
        clear_logs();
        write_burst(9'h010, 4'd7, 16'hB000);
        @(negedge clk);
        clear_logs();
        rdata_ready = 1'b1;
        send_req(1'b0, 9'h010, 4'd7);
        for (int i = 0; i < 40; i++) begin
            rdata_ready = !(i >= 2 && i < 7);
            @(negedge clk); #1;
            if (!busy) break;
        end
        chk("stall_idle", busy, 0);
        rdata_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'hB000 + 16'(i)});
        chk("stall_max_outstanding", max_out, 2);
        chk("stall_issue_count", iss_cyc.size(), 8);
        check_reads("rd_stall");

        // 5: write with gaps in wdata_valid
        @(negedge clk);
        clear_logs();
        send_req(1'b1, 9'h040, 4'd3);
        begin
            logic [5:0] pat;
            logic [DW-1:0] d;
            pat = 6'b110101;   // applied LSB first: 1,0,1,0,1,1
            d = 16'hC000;
            for (int i = 0; i < 6; i++) begin
                wdata_valid = pat[i];
                wdata = pat[i] ? d : 16'hDEAD;
                @(negedge clk);
                if (pat[i]) d = d + 16'd1;
            end
        end
        wdata_valid = 1'b0;
        #1;
        chk("gap_busy_after_last", busy, 0);
        chk("gap_me_without_valid", bad_me, 0);
        for (int i = 0; i < 4; i++) exp_wq.push_back({9'h040 + 9'(i), 16'hC000 + 16'(i)});
        check_writes("wr_gap");

        // 6: reset in the middle of a read with the buffer full
        @(negedge clk);
        clear_logs();
        rdata_ready = 1'b0;
        send_req(1'b0, 9'h010, 4'd7);
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_rvalid", rdata_valid, 1);
        rst = 1'b1;
        #1;
        chk("in_rst_me", sram_me, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_rvalid", rdata_valid, 0);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_me", sram_me, 0);
        @(negedge clk);
        clear_logs();
        rdata_ready = 1'b1;
        send_req(1'b0, 9'h000, 4'd0);
        wait_idle(20);
        exp_q.push_back({1'b1, 16'hA002});
        check_reads("rd_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
